// File: rtl/aoc2_pkg.sv
// Shared definitions for the group-count query path: data width, the
// decimal power table used for digit counting and decade splitting, and
// the range dispatcher state encoding.
package aoc2_pkg;

    // Width of IDs, prefix bounds and engine responses.
    localparam int DATA_WIDTH = 64;

    // Largest legal digit count; must fit a 4-bit digit field.
    localparam int MAX_DIGS = 15;

    // POW10[i] = 10^i for i = 0..MAX_DIGS.
    localparam logic [DATA_WIDTH-1:0] POW10 [0:MAX_DIGS] = '{
        64'd1,
        64'd10,
        64'd100,
        64'd1000,
        64'd10000,
        64'd100000,
        64'd1000000,
        64'd10000000,
        64'd100000000,
        64'd1000000000,
        64'd10000000000,
        64'd100000000000,
        64'd1000000000000,
        64'd10000000000000,
        64'd100000000000000,
        64'd1000000000000000
    };

    // Range dispatcher states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEG  = 3'd1,
        Q_HI = 3'd2,
        W_HI = 3'd3,
        Q_LO = 3'd4,
        W_LO = 3'd5,
        NEXT = 3'd6,
        DONE = 3'd7
    } dispatch_state_t;

endpackage

// File: rtl/digit_count.sv
// Decimal digit count of x by priority compare against the POW10 table.
// digits(0) = 1; values at or above 10^(MAX_D-1) report MAX_D.
module digit_count
    import aoc2_pkg::*;
#(
    parameter int MAX_D = aoc2_pkg::MAX_DIGS
) (
    input  logic [DATA_WIDTH-1:0] x,
    output logic [3:0]            digs
);

    // Smallest i with x < 10^i wins; the loop runs high to low so the
    // last matching (smallest) threshold is the one that sticks.
    always_comb begin
        digs = 4'(MAX_D);
        for (int i = MAX_D - 1; i >= 1; i--) begin
            if (x < POW10[i]) begin
                digs = 4'(i);
            end
        end
    end

endmodule

// File: rtl/range_dispatch.sv
// Range dispatcher: takes an inclusive ID range [lo, hi], splits it at
// decade boundaries, and for each fixed-digit segment [a, b] asks the
// group-count engine for f(b) and, when a is not the first value of the
// decade, f(a-1). The range total is the sum of f(b) - f(a-1).
//
// Optional build macro RANGE_DISPATCH_ERR_EN adds an err output that flags
// lo > hi or hi >= 10^MAX_DIGS; such a range is answered with a zero total
// and no engine queries.
module range_dispatch
    import aoc2_pkg::*;
#(
    parameter int MAX_DIGS  = aoc2_pkg::MAX_DIGS,
    parameter int ACC_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rng_valid,
    output logic                  rng_ready,
    input  logic [DATA_WIDTH-1:0] rng_lo,
    input  logic [DATA_WIDTH-1:0] rng_hi,
    output logic                  query_start,
    output logic [DATA_WIDTH-1:0] query_n,
    output logic [3:0]            query_digs,
    input  logic                  resp_valid,
    input  logic [DATA_WIDTH-1:0] resp_count,
    output logic                  sum_valid,
    input  logic                  sum_ready,
    output logic [ACC_WIDTH-1:0]  sum_out
`ifdef RANGE_DISPATCH_ERR_EN
    ,
    output logic                  err
`endif
);

    dispatch_state_t       state_reg;
    logic [DATA_WIDTH-1:0] hi_reg;
    logic [DATA_WIDTH-1:0] seg_lo_reg;
    logic [3:0]            d_reg;
    logic                  needs_lo_reg;
    logic [ACC_WIDTH-1:0]  acc_reg;

`ifdef RANGE_DISPATCH_ERR_EN
    logic [DATA_WIDTH-1:0] lo_reg;
    logic                  first_reg;
    logic                  err_reg;
    logic                  range_bad;
`endif

    // Segment geometry derived from the current segment start.
    logic [3:0]            seg_digs;
    logic [DATA_WIDTH-1:0] pow_d;
    logic [DATA_WIDTH-1:0] pow_dm1;
    logic [DATA_WIDTH-1:0] seg_top;
    logic [DATA_WIDTH-1:0] seg_hi_next;
    logic [DATA_WIDTH-1:0] pow_next;
    logic                  resp_fresh;

    digit_count #(
        .MAX_D (MAX_DIGS)
    ) u_digit_count (
        .x    (seg_lo_reg),
        .digs (seg_digs)
    );

    // Decade bounds of the segment starting at seg_lo_reg, and the start
    // of the following decade for the NEXT step.
    always_comb begin
        pow_d       = POW10[seg_digs];
        pow_dm1     = POW10[seg_digs - 4'd1];
        seg_top     = pow_d - 1'b1;
        seg_hi_next = (hi_reg < seg_top) ? hi_reg : seg_top;
        pow_next    = POW10[d_reg];
    end

    // A response level that is still high in the query_start cycle belongs
    // to the previous query; only later cycles carry the new answer.
    assign resp_fresh = resp_valid & ~query_start;

`ifdef RANGE_DISPATCH_ERR_EN
    assign range_bad = (lo_reg > hi_reg) || (hi_reg >= POW10[MAX_DIGS]);
`endif

    // Main sequencer: segment split, query issue, response accumulation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            hi_reg       <= '0;
            seg_lo_reg   <= '0;
            d_reg        <= '0;
            needs_lo_reg <= 1'b0;
            acc_reg      <= '0;
            query_start  <= 1'b0;
            query_n      <= '0;
            query_digs   <= '0;
`ifdef RANGE_DISPATCH_ERR_EN
            lo_reg       <= '0;
            first_reg    <= 1'b0;
            err_reg      <= 1'b0;
`endif
        end else begin
            query_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rng_valid) begin
                        hi_reg     <= rng_hi;
                        // Zero contributes nothing; start the split at 1 so
                        // the first segment is the one-digit decade.
                        seg_lo_reg <= (rng_lo == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : rng_lo;
                        acc_reg    <= '0;
`ifdef RANGE_DISPATCH_ERR_EN
                        lo_reg     <= rng_lo;
                        first_reg  <= 1'b1;
                        err_reg    <= 1'b0;
`endif
                        state_reg  <= SEG;
                    end
                end

                SEG: begin
`ifdef RANGE_DISPATCH_ERR_EN
                    if (first_reg && range_bad) begin
                        acc_reg   <= '0;
                        err_reg   <= 1'b1;
                        first_reg <= 1'b0;
                        state_reg <= DONE;
                    end else
`endif
                    begin
                        // The query operands are registered here so they are
                        // stable a full cycle ahead of query_start.
                        d_reg        <= seg_digs;
                        needs_lo_reg <= (seg_lo_reg != pow_dm1);
                        query_n      <= seg_hi_next;
                        query_digs   <= seg_digs;
`ifdef RANGE_DISPATCH_ERR_EN
                        first_reg    <= 1'b0;
`endif
                        state_reg    <= Q_HI;
                    end
                end

                Q_HI: begin
                    query_start <= 1'b1;
                    state_reg   <= W_HI;
                end

                W_HI: begin
                    if (resp_fresh) begin
                        acc_reg <= acc_reg + ACC_WIDTH'(resp_count);
                        if (needs_lo_reg) begin
                            query_n   <= seg_lo_reg - 1'b1;
                            state_reg <= Q_LO;
                        end else begin
                            state_reg <= NEXT;
                        end
                    end
                end

                Q_LO: begin
                    query_start <= 1'b1;
                    state_reg   <= W_LO;
                end

                W_LO: begin
                    if (resp_fresh) begin
                        // May wrap transiently; the segment difference is
                        // non-negative once both halves are in.
                        acc_reg   <= acc_reg - ACC_WIDTH'(resp_count);
                        state_reg <= NEXT;
                    end
                end

                NEXT: begin
                    seg_lo_reg <= pow_next;
                    // At MAX_DIGS there is no further decade to visit.
                    if ((d_reg < 4'(MAX_DIGS)) && (pow_next <= hi_reg)) begin
                        state_reg <= SEG;
                    end else begin
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    if (sum_ready) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rng_ready = (state_reg == IDLE);
    assign sum_valid = (state_reg == DONE);
    assign sum_out   = sum_valid ? acc_reg : '0;

`ifdef RANGE_DISPATCH_ERR_EN
    assign err = err_reg;
`endif

endmodule

// File: tb/tb_range_dispatch.sv
// Directed bench for range_dispatch with a behavioural group-count engine.
// The engine answers with the sum of d-digit IDs made of one digit string
// repeated twice that are <= n, after a programmable latency.
module tb_range_dispatch;
    import aoc2_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int AW = 64;

    logic          clock;
    logic          reset;
    logic          rng_valid;
    logic          rng_ready;
    logic [DW-1:0] rng_lo;
    logic [DW-1:0] rng_hi;
    logic          query_start;
    logic [DW-1:0] query_n;
    logic [3:0]    query_digs;
    logic          resp_valid;
    logic [DW-1:0] resp_count;
    logic          sum_valid;
    logic          sum_ready;
    logic [AW-1:0] sum_out;
`ifdef RANGE_DISPATCH_ERR_EN
    logic          err;
`endif

    range_dispatch #(
        .MAX_DIGS  (15),
        .ACC_WIDTH (AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rng_valid   (rng_valid),
        .rng_ready   (rng_ready),
        .rng_lo      (rng_lo),
        .rng_hi      (rng_hi),
        .query_start (query_start),
        .query_n     (query_n),
        .query_digs  (query_digs),
        .resp_valid  (resp_valid),
        .resp_count  (resp_count),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready),
        .sum_out     (sum_out)
`ifdef RANGE_DISPATCH_ERR_EN
        ,
        .err         (err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Engine model state
    int            eng_lat = 1;
    int            eng_cnt = 0;
    int            hold_viol = 0;
    int            setup_viol = 0;
    logic [DW-1:0] cap_n;
    logic [3:0]    cap_d;
    logic [DW-1:0] prev_n = '0;
    logic [3:0]    prev_d = '0;
    logic [DW-1:0] log_n [$];
    logic [3:0]    log_d [$];

    // Sum of d-digit values of the form k*(10^(d/2)+1) not exceeding n.
    function automatic logic [DW-1:0] golden(input logic [DW-1:0] n, input int d);
        logic [DW-1:0] s, hp, mul;
        s = '0;
        if ((d % 2) != 0 || d == 0) return s;
        hp = 1;
        for (int i = 0; i < d / 2; i++) hp = hp * 10;
        mul = hp + 1;
        for (logic [DW-1:0] k = hp / 10; k < hp; k++) begin
            if (k * mul <= n) s = s + k * mul;
        end
        return s;
    endfunction

    // Engine: captures each query, holds the previous response level through
    // the query_start cycle, then answers after eng_lat cycles.
    always @(negedge clock) begin
        if (reset) begin
            eng_cnt    = 0;
            resp_valid = 1'b0;
            resp_count = '0;
        end else if (query_start) begin
            if (query_n !== prev_n || query_digs !== prev_d) setup_viol = setup_viol + 1;
            cap_n = query_n;
            cap_d = query_digs;
            log_n.push_back(query_n);
            log_d.push_back(query_digs);
            eng_cnt = eng_lat;
        end else if (eng_cnt > 0) begin
            if (query_n !== cap_n || query_digs !== cap_d) hold_viol = hold_viol + 1;
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) begin
                resp_valid = 1'b1;
                resp_count = golden(cap_n, int'(cap_d));
            end else begin
                resp_valid = 1'b0;
                resp_count = 64'h0BAD_0BAD_0BAD_0BAD;
            end
        end
        prev_n = query_n;
        prev_d = query_digs;
    end

    // Offer a range and release it after one accepting edge.
    task automatic start_range(input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        @(negedge clock);
        rng_lo    = lo;
        rng_hi    = hi;
        rng_valid = 1'b1;
        @(posedge clock);
        #1 rng_valid = 1'b0;
    endtask

    // Wait for sum_valid with a cycle budget; returns at a negedge.
    task automatic wait_sum(output bit ok, output logic [AW-1:0] got);
        ok  = 1'b0;
        got = '0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clock);
            if (sum_valid === 1'b1) begin
                ok  = 1'b1;
                got = sum_out;
            end
        end
    endtask

    task automatic release_sum();
        sum_ready = 1'b1;
        @(posedge clock);
        #1 sum_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (rng_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rng_ready got=%b want=1", rng_ready); end
        n_cmp++; if (query_start !== 1'b0) begin n_fail++; $display("FAIL reset_query_start got=%b want=0", query_start); end
        n_cmp++; if (query_n !== '0) begin n_fail++; $display("FAIL reset_query_n got=%0d want=0", query_n); end
        n_cmp++; if (query_digs !== 4'd0) begin n_fail++; $display("FAIL reset_query_digs got=%0d want=0", query_digs); end
        n_cmp++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sum_valid got=%b want=0", sum_valid); end
        n_cmp++; if (sum_out !== '0) begin n_fail++; $display("FAIL reset_sum_out got=%0d want=0", sum_out); end
        reset = 1'b0;
        @(negedge clock);
        $display("reset: rng_ready=%b sum_valid=%b", rng_ready, sum_valid);
    endtask

    task automatic test_single_decade();
        bit ok; logic [AW-1:0] got; int base, hv, sv;
        eng_lat = 1; base = log_n.size(); hv = hold_viol; sv = setup_viol;
        start_range(11, 22);
        wait_sum(ok, got);
        $display("range [11,22] sum=%0d queries=%0d", got, log_n.size() - base);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL r11_22_timeout got=none want=sum_valid"); end
        n_cmp++; if (got !== 64'd33) begin n_fail++; $display("FAIL r11_22_sum got=%0d want=33", got); end
        n_cmp++; if (log_n.size() - base != 2) begin n_fail++; $display("FAIL r11_22_nq got=%0d want=2", log_n.size() - base); end
        else begin
            n_cmp++; if (log_n[base] !== 64'd22 || log_d[base] !== 4'd2) begin n_fail++; $display("FAIL r11_22_q0 got=(%0d,%0d) want=(22,2)", log_n[base], log_d[base]); end
            n_cmp++; if (log_n[base+1] !== 64'd10 || log_d[base+1] !== 4'd2) begin n_fail++; $display("FAIL r11_22_q1 got=(%0d,%0d) want=(10,2)", log_n[base+1], log_d[base+1]); end
        end
        n_cmp++; if (setup_viol != sv || hold_viol != hv) begin n_fail++; $display("FAIL r11_22_stable got=setup%0d/hold%0d want=0/0", setup_viol - sv, hold_viol - hv); end
        release_sum();
        @(negedge clock);
        n_cmp++; if (rng_ready !== 1'b1 || sum_valid !== 1'b0) begin n_fail++; $display("FAIL r11_22_release got=ready%b/valid%b want=1/0", rng_ready, sum_valid); end
    endtask

    task automatic test_two_segments();
        bit ok; logic [AW-1:0] got; int base;
        eng_lat = 3; base = log_n.size();
        start_range(95, 115);
        wait_sum(ok, got);
        $display("range [95,115] sum=%0d queries=%0d", got, log_n.size() - base);
        n_cmp++; if (!ok || got !== 64'd99) begin n_fail++; $display("FAIL r95_115_sum got=%0d want=99", got); end
        n_cmp++; if (log_n.size() - base != 3) begin n_fail++; $display("FAIL r95_115_nq got=%0d want=3", log_n.size() - base); end
        else begin
            n_cmp++; if (log_n[base] !== 64'd99 || log_d[base] !== 4'd2) begin n_fail++; $display("FAIL r95_115_q0 got=(%0d,%0d) want=(99,2)", log_n[base], log_d[base]); end
            n_cmp++; if (log_n[base+1] !== 64'd94 || log_d[base+1] !== 4'd2) begin n_fail++; $display("FAIL r95_115_q1 got=(%0d,%0d) want=(94,2)", log_n[base+1], log_d[base+1]); end
            n_cmp++; if (log_n[base+2] !== 64'd115 || log_d[base+2] !== 4'd3) begin n_fail++; $display("FAIL r95_115_q2 got=(%0d,%0d) want=(115,3)", log_n[base+2], log_d[base+2]); end
        end
        release_sum();
    endtask

    task automatic test_skip_lo();
        bit ok; logic [AW-1:0] got; int base;
        eng_lat = 2; base = log_n.size();
        start_range(1, 9);
        wait_sum(ok, got);
        $display("range [1,9] sum=%0d queries=%0d", got, log_n.size() - base);
        n_cmp++; if (!ok || got !== 64'd0) begin n_fail++; $display("FAIL r1_9_sum got=%0d want=0", got); end
        n_cmp++; if (log_n.size() - base != 1) begin n_fail++; $display("FAIL r1_9_nq got=%0d want=1", log_n.size() - base); end
        else begin
            n_cmp++; if (log_n[base] !== 64'd9 || log_d[base] !== 4'd1) begin n_fail++; $display("FAIL r1_9_q0 got=(%0d,%0d) want=(9,1)", log_n[base], log_d[base]); end
        end
        release_sum();
    endtask

    task automatic test_stale_resp();
        bit ok; logic [AW-1:0] got; int base, hv, sv;
        eng_lat = 2; base = log_n.size(); hv = hold_viol; sv = setup_viol;
        start_range(998, 1012);
        wait_sum(ok, got);
        $display("range [998,1012] sum=%0d queries=%0d", got, log_n.size() - base);
        n_cmp++; if (!ok || got !== 64'd1010) begin n_fail++; $display("FAIL r998_1012_sum got=%0d want=1010", got); end
        n_cmp++; if (log_n.size() - base != 3) begin n_fail++; $display("FAIL r998_1012_nq got=%0d want=3", log_n.size() - base); end
        else begin
            n_cmp++; if (log_n[base+1] !== 64'd997 || log_d[base+1] !== 4'd3) begin n_fail++; $display("FAIL r998_1012_q1 got=(%0d,%0d) want=(997,3)", log_n[base+1], log_d[base+1]); end
            n_cmp++; if (log_n[base+2] !== 64'd1012 || log_d[base+2] !== 4'd4) begin n_fail++; $display("FAIL r998_1012_q2 got=(%0d,%0d) want=(1012,4)", log_n[base+2], log_d[base+2]); end
        end
        n_cmp++; if (setup_viol != sv || hold_viol != hv) begin n_fail++; $display("FAIL r998_1012_stable got=setup%0d/hold%0d want=0/0", setup_viol - sv, hold_viol - hv); end
        release_sum();
    endtask

    task automatic test_boundaries();
        bit ok; logic [AW-1:0] got; int base;
        eng_lat = 1;
        base = log_n.size();
        start_range(55, 55);
        wait_sum(ok, got);
        $display("range [55,55] sum=%0d queries=%0d", got, log_n.size() - base);
        n_cmp++; if (!ok || got !== 64'd55 || log_n.size() - base != 2) begin n_fail++; $display("FAIL r55_55 got=%0d/%0dq want=55/2q", got, log_n.size() - base); end
        release_sum();
        base = log_n.size();
        start_range(10, 99);
        wait_sum(ok, got);
        $display("range [10,99] sum=%0d queries=%0d", got, log_n.size() - base);
        n_cmp++; if (!ok || got !== 64'd495 || log_n.size() - base != 1) begin n_fail++; $display("FAIL r10_99 got=%0d/%0dq want=495/1q", got, log_n.size() - base); end
        release_sum();
        base = log_n.size();
        start_range(0, 12);
        wait_sum(ok, got);
        $display("range [0,12] sum=%0d queries=%0d", got, log_n.size() - base);
        n_cmp++; if (!ok || got !== 64'd11 || log_n.size() - base != 2) begin n_fail++; $display("FAIL r0_12 got=%0d/%0dq want=11/2q", got, log_n.size() - base); end
        else begin
            n_cmp++; if (log_n[base] !== 64'd9 || log_d[base] !== 4'd1) begin n_fail++; $display("FAIL r0_12_q0 got=(%0d,%0d) want=(9,1)", log_n[base], log_d[base]); end
        end
        release_sum();
    endtask

    task automatic test_stall();
        bit ok; logic [AW-1:0] got; int bad;
        eng_lat = 1; bad = 0;
        start_range(95, 115);
        wait_sum(ok, got);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (sum_valid !== 1'b1 || sum_out !== 64'd99) bad++;
        end
        $display("range [95,115] stalled sum=%0d bad_cycles=%0d", got, bad);
        n_cmp++; if (!ok || bad != 0) begin n_fail++; $display("FAIL stall_hold got=%0d_bad_cycles want=0", bad); end
        release_sum();
    endtask

    task automatic test_reset_mid();
        bit ok, reached; logic [AW-1:0] got; int base, seen;
        eng_lat = 3; base = log_n.size(); seen = 0; reached = 1'b0;
        start_range(95, 115);
        for (int c = 0; c < 100 && !reached; c++) begin
            @(negedge clock);
            if (sum_valid === 1'b1) seen++;
            if (log_n.size() - base >= 2) reached = 1'b1;
        end
        n_cmp++; if (!reached) begin n_fail++; $display("FAIL abort_reach_wlo got=%0dq want=2q", log_n.size() - base); end
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (query_start !== 1'b0 || rng_ready !== 1'b1) begin n_fail++; $display("FAIL abort_async got=start%b/ready%b want=0/1", query_start, rng_ready); end
        @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (sum_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0 || rng_ready !== 1'b1) begin n_fail++; $display("FAIL abort_no_sum got=%0d_valid/ready%b want=0/1", seen, rng_ready); end
        eng_lat = 1;
        start_range(11, 22);
        wait_sum(ok, got);
        $display("range [11,22] after abort sum=%0d", got);
        n_cmp++; if (!ok || got !== 64'd33) begin n_fail++; $display("FAIL abort_next_sum got=%0d want=33", got); end
        release_sum();
    endtask

`ifdef RANGE_DISPATCH_ERR_EN
    task automatic test_err();
        bit ok; logic [AW-1:0] got; int base, bad;
        base = log_n.size(); bad = 0;
        start_range(50, 10);
        wait_sum(ok, got);
        n_cmp++; if (!ok || got !== '0 || err !== 1'b1) begin n_fail++; $display("FAIL err_flag got=%0d/err%b want=0/err1", got, err); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (sum_valid !== 1'b1 || sum_out !== '0 || err !== 1'b1) bad++;
        end
        $display("range [50,10] sum=%0d err=%b stall_bad=%0d", got, err, bad);
        n_cmp++; if (bad != 0 || log_n.size() != base) begin n_fail++; $display("FAIL err_stall got=%0d_bad/%0dq want=0/0q", bad, log_n.size() - base); end
        release_sum();
        start_range(11, 22);
        wait_sum(ok, got);
        n_cmp++; if (!ok || got !== 64'd33 || err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%0d/err%b want=33/err0", got, err); end
        release_sum();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        rng_valid = 1'b0;
        rng_lo    = '0;
        rng_hi    = '0;
        sum_ready = 1'b0;
        test_reset();
        test_single_decade();
        test_two_segments();
        test_skip_lo();
        test_stale_resp();
        test_boundaries();
        test_stall();
        test_reset_mid();
`ifdef RANGE_DISPATCH_ERR_EN
        test_err();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
